// File: rtl/mod_imm_gen.sv
// Immediate extender (zero/sign/upper/branch) feeding a 2-entry in-order skid buffer.
// Latency: 1 cycle from acceptance to out_valid; 1 item/cycle sustained.
// Backpressure: in_ready = (count != 2), driven from registered state only.
module mod_imm_gen #(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IMM_W-1:0] in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       count
);

    localparam int PAD_W = OUT_W - IMM_W;

    generate
        if (IMM_W < 1 || IMM_W > OUT_W - 2) begin : g_bad_param
            $error("mod_imm_gen: IMM_W must satisfy 1 <= IMM_W <= OUT_W-2");
        end
    endgenerate

    logic [OUT_W-1:0] slot0_imm_q, slot0_imm_d;
    logic [OUT_W-1:0] slot1_imm_q, slot1_imm_d;
    logic [TAG_W-1:0] slot0_tag_q, slot0_tag_d;
    logic [TAG_W-1:0] slot1_tag_q, slot1_tag_d;
    logic [1:0]       count_q, count_d;

    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] new_imm;
    logic             push;
    logic             pop;

    always_comb begin
        sign_ext = {{PAD_W{in_imm[IMM_W-1]}}, in_imm};
        new_imm  = '0;
        unique case (in_mode)
            2'd0: new_imm = {{PAD_W{1'b0}}, in_imm};
            2'd1: new_imm = sign_ext;
            2'd2: new_imm = {in_imm, {PAD_W{1'b0}}};
            2'd3: new_imm = {sign_ext[OUT_W-3:0], 2'b00};
            default: new_imm = '0;
        endcase
    end

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_imm   = slot0_imm_q;
    assign out_tag   = slot0_tag_q;
    assign count     = count_q;

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // slot0 is always the head; slot1 only ever holds the second-oldest entry.
    always_comb begin
        slot0_imm_d = slot0_imm_q;
        slot0_tag_d = slot0_tag_q;
        slot1_imm_d = slot1_imm_q;
        slot1_tag_d = slot1_tag_q;
        count_d     = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        slot0_imm_d = new_imm;
                        slot0_tag_d = in_tag;
                    end else begin
                        slot1_imm_d = new_imm;
                        slot1_tag_d = in_tag;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    slot0_imm_d = slot1_imm_q;
                    slot0_tag_d = slot1_tag_q;
                    count_d     = count_q - 2'd1;
                end
                2'b11: begin
                    // Only reachable at count 1: the new entry becomes the head.
                    slot0_imm_d = new_imm;
                    slot0_tag_d = in_tag;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot0_imm_q <= '0;
            slot0_tag_q <= '0;
            slot1_imm_q <= '0;
            slot1_tag_q <= '0;
            count_q     <= 2'd0;
        end else begin
            slot0_imm_q <= slot0_imm_d;
            slot0_tag_q <= slot0_tag_d;
            slot1_imm_q <= slot1_imm_d;
            slot1_tag_q <= slot1_tag_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: tb/tb_mod_imm_gen.sv
// Directed bench for mod_imm_gen (default and IMM_W=12 builds) plus a queue-model soak.
module tb_mod_imm_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default build (IMM_W=16)
    logic        flush0, iv0, ir0, ov0, or0;
    logic [15:0] imm0;
    logic [1:0]  mode0, cnt0;
    logic [4:0]  tag0, otag0;
    logic [31:0] oimm0;

    // IMM_W=12 build
    logic        flush1, iv1, ir1, ov1, or1;
    logic [11:0] imm1;
    logic [1:0]  mode1, cnt1;
    logic [4:0]  tag1, otag1;
    logic [31:0] oimm1;

    mod_imm_gen u_dut0 (
        .clk(clk), .rst(rst), .flush(flush0),
        .in_valid(iv0), .in_ready(ir0), .in_imm(imm0), .in_mode(mode0), .in_tag(tag0),
        .out_valid(ov0), .out_ready(or0), .out_imm(oimm0), .out_tag(otag0), .count(cnt0)
    );

    mod_imm_gen #(.IMM_W(12), .OUT_W(32), .TAG_W(5)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush1),
        .in_valid(iv1), .in_ready(ir1), .in_imm(imm1), .in_mode(mode1), .in_tag(tag1),
        .out_valid(ov1), .out_ready(or1), .out_imm(oimm1), .out_tag(otag1), .count(cnt1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref12(input logic [11:0] imm, input logic [1:0] m);
        logic signed [31:0] sx;
        sx = $signed(imm);
        case (m)
            2'd0: return {20'd0, imm};
            2'd1: return sx;
            2'd2: return {imm, 20'd0};
            default: return 32'(sx * 4);
        endcase
    endfunction

    // Directed vectors: {imm, mode, expected}
    logic [15:0] v0_imm [7] = '{16'h8004, 16'h8004, 16'h8004, 16'h8004, 16'h7FFF, 16'h7FFF, 16'hFFFF};
    logic [1:0]  v0_mode[7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd3, 2'd2};
    logic [31:0] v0_exp [7] = '{32'h00008004, 32'hFFFF8004, 32'h80040000, 32'hFFFE0010,
                                32'h00007FFF, 32'h0001FFFC, 32'hFFFF0000};
    logic [11:0] v1_imm [6] = '{12'h800, 12'h800, 12'h800, 12'h800, 12'h7FF, 12'h7FF};
    logic [1:0]  v1_mode[6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd3};
    logic [31:0] v1_exp [6] = '{32'h00000800, 32'hFFFFF800, 32'h80000000, 32'hFFFFE000,
                                32'h000007FF, 32'h00001FFC};

    logic [31:0] q_imm[$];
    logic [4:0]  q_tag[$];

    initial begin
        rst = 1'b1;
        flush0 = 1'b0; iv0 = 1'b0; imm0 = '0; mode0 = '0; tag0 = '0; or0 = 1'b0;
        flush1 = 1'b0; iv1 = 1'b0; imm1 = '0; mode1 = '0; tag1 = '0; or1 = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_count", 32'(cnt0), 32'd0);
        chk("rst_out_valid", 32'(ov0), 32'd0);
        chk("rst_in_ready", 32'(ir0), 32'd1);
        chk("rst_out_imm", oimm0, 32'd0);
        chk("rst_out_tag", 32'(otag0), 32'd0);

        // Mode sweep, default widths
        for (int i = 0; i < 7; i++) begin
            iv0 = 1'b1; imm0 = v0_imm[i]; mode0 = v0_mode[i]; tag0 = 5'(i + 1); or0 = 1'b1;
            step();
            iv0 = 1'b0;
            chk($sformatf("sweep0_vld[%0d]", i), 32'(ov0), 32'd1);
            chk($sformatf("sweep0_imm[%0d]", i), oimm0, v0_exp[i]);
            chk($sformatf("sweep0_tag[%0d]", i), 32'(otag0), 32'(i + 1));
            step();
            chk($sformatf("sweep0_drain[%0d]", i), 32'(cnt0), 32'd0);
        end

        // Back-pressure: tags 1,2 accepted, 3 held off
        or0 = 1'b0; mode0 = 2'd0;
        iv0 = 1'b1; tag0 = 5'd1; imm0 = 16'h0001; step();
        tag0 = 5'd2; imm0 = 16'h0002; step();
        chk("bp_count_full", 32'(cnt0), 32'd2);
        chk("bp_in_ready_low", 32'(ir0), 32'd0);
        tag0 = 5'd3; imm0 = 16'h0003; step();
        chk("bp_count_held", 32'(cnt0), 32'd2);
        chk("bp_in_ready_held", 32'(ir0), 32'd0);
        chk("bp_head_stable", 32'(otag0), 32'd1);
        or0 = 1'b1; step();
        chk("bp_rel1_tag", 32'(otag0), 32'd2);
        chk("bp_rel1_count", 32'(cnt0), 32'd1);
        chk("bp_rel1_in_ready", 32'(ir0), 32'd1);
        step();
        iv0 = 1'b0;
        chk("bp_rel2_tag", 32'(otag0), 32'd3);
        chk("bp_rel2_imm", oimm0, 32'h00000003);
        chk("bp_rel2_count", 32'(cnt0), 32'd1);
        step();
        chk("bp_drained", 32'(cnt0), 32'd0);

        // Simultaneous push/pop at count 1
        or0 = 1'b0; iv0 = 1'b1; tag0 = 5'd7; imm0 = 16'h0070; step();
        or0 = 1'b1; tag0 = 5'd8; imm0 = 16'h0080; step();
        iv0 = 1'b0;
        chk("pp_count", 32'(cnt0), 32'd1);
        chk("pp_head_tag", 32'(otag0), 32'd8);
        chk("pp_head_imm", oimm0, 32'h00000080);
        step();
        chk("pp_drained", 32'(cnt0), 32'd0);

        // Flush with count 2 and a same-cycle input
        or0 = 1'b0; iv0 = 1'b1; tag0 = 5'd10; step();
        tag0 = 5'd11; step();
        chk("fl_pre_count", 32'(cnt0), 32'd2);
        flush0 = 1'b1; or0 = 1'b1; tag0 = 5'd12; step();
        flush0 = 1'b0; iv0 = 1'b0;
        chk("fl_count", 32'(cnt0), 32'd0);
        chk("fl_out_valid", 32'(ov0), 32'd0);
        chk("fl_in_ready", 32'(ir0), 32'd1);
        step();
        chk("fl_no_ghost", 32'(cnt0), 32'd0);

        // Mid-operation reset at count 2
        or0 = 1'b0; iv0 = 1'b1; mode0 = 2'd0; imm0 = 16'h1234; tag0 = 5'd20; step();
        tag0 = 5'd21; step();
        iv0 = 1'b0;
        chk("mr_pre_count", 32'(cnt0), 32'd2);
        rst = 1'b1; or0 = 1'b1; step();
        rst = 1'b0;
        chk("mr_count", 32'(cnt0), 32'd0);
        chk("mr_out_valid", 32'(ov0), 32'd0);
        chk("mr_in_ready", 32'(ir0), 32'd1);
        chk("mr_out_imm", oimm0, 32'd0);
        chk("mr_out_tag", 32'(otag0), 32'd0);

        // Mode sweep, IMM_W=12
        for (int i = 0; i < 6; i++) begin
            iv1 = 1'b1; imm1 = v1_imm[i]; mode1 = v1_mode[i]; tag1 = 5'(i + 4); or1 = 1'b1;
            step();
            iv1 = 1'b0;
            chk($sformatf("sweep1_vld[%0d]", i), 32'(ov1), 32'd1);
            chk($sformatf("sweep1_imm[%0d]", i), oimm1, v1_exp[i]);
            chk($sformatf("sweep1_tag[%0d]", i), 32'(otag1), 32'(i + 4));
            step();
        end

        // Randomised push/pop/flush against a queue model, IMM_W=12
        q_imm.delete();
        q_tag.delete();
        chk("rnd_start_empty", 32'(cnt1), 32'd0);
        for (int c = 0; c < 10000; c++) begin
            logic do_push, do_pop;
            chk("rnd_count", 32'(cnt1), 32'(q_imm.size()));
            chk("rnd_in_ready", 32'(ir1), 32'(q_imm.size() != 2));
            chk("rnd_out_valid", 32'(ov1), 32'(q_imm.size() != 0));
            if (q_imm.size() != 0) begin
                chk("rnd_head_imm", oimm1, q_imm[0]);
                chk("rnd_head_tag", 32'(otag1), 32'(q_tag[0]));
            end
            iv1    = ($urandom_range(0, 3) != 0);
            or1    = ($urandom_range(0, 2) != 0);
            flush1 = ($urandom_range(0, 63) == 0);
            imm1   = 12'($urandom);
            mode1  = 2'($urandom_range(0, 3));
            tag1   = 5'($urandom);
            if (flush1) begin
                q_imm.delete();
                q_tag.delete();
            end else begin
                do_pop  = (q_imm.size() != 0) && or1;
                do_push = iv1 && (q_imm.size() != 2);
                if (do_pop) begin
                    void'(q_imm.pop_front());
                    void'(q_tag.pop_front());
                end
                if (do_push) begin
                    q_imm.push_back(ref12(imm1, mode1));
                    q_tag.push_back(tag1);
                end
            end
            step();
        end
        flush1 = 1'b0; iv1 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mod_imm_gen.md
# mod_imm_gen

Parametrised, buffered immediate generator for the decode/execute boundary of the pipelined MIPS core. Accepts a raw instruction immediate plus a 2-bit mode, extends or shifts it to `OUT_W` bits, and holds results in a 2-entry in-order skid buffer behind a valid/ready handshake. The buffer lets decode keep issuing for one cycle after execute stalls. `flush` discards all buffered results on a branch or exception redirect.

## Interface
- `IMM_W`, 16, raw immediate width; legal range 1 ≤ `IMM_W` ≤ `OUT_W` − 2.
- `OUT_W`, 32, result width.
- `TAG_W`, 5, width of the sideband tag (e.g. destination register) carried alongside each result.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous clear of buffered entries; does not reset configuration.
- `in_valid`  in  1  producer has an immediate to deliver.
- `in_ready`  out  1  block can accept this cycle.
- `in_imm`  in  `IMM_W`  raw immediate.
- `in_mode`  in  2  0 = zero-ext, 1 = sign-ext, 2 = upper (LUI), 3 = branch offset.
- `in_tag`  in  `TAG_W`  sideband tag, passed through unchanged.
- `out_valid`  out  1  head entry is valid.
- `out_ready`  in  1  consumer takes the head entry this cycle.
- `out_imm`  out  `OUT_W`  extended immediate of the head entry.
- `out_tag`  out  `TAG_W`  tag of the head entry.
- `count`  out  2  occupancy, 0..2.

## Operation
- Result formats, computed when an entry is pushed and stored as `OUT_W` bits:
  - Mode 0: `{(OUT_W-IMM_W)'0, imm}`.
  - Mode 1: `{(OUT_W-IMM_W){imm[IMM_W-1]}, imm}`.
  - Mode 2: `imm << (OUT_W-IMM_W)`, so the low bits are 0. With defaults this gives `imm << 16`.
  - Mode 3: the mode-1 value shifted left by 2; the top 2 bits are dropped and bits [1:0] are 0.
- Storage is a 2-entry FIFO (head/tail, or a slot-0/slot-1 shift arrangement). Order is strictly preserved.
- Push happens when `in_valid && in_ready && !flush`.
- Pop happens when `out_valid && out_ready && !flush`.
- `in_ready = (count != 2)`. This is a function of state only; there is no combinational path from `out_ready` or `in_valid`.
- `out_valid = (count != 0)`.
- `out_imm` and `out_tag` come from the head register only, never from the input bus.
- Push and pop in the same cycle leave `count` unchanged.
  - At `count` = 1, the head is replaced by the new entry.
  - `count` = 2 with push and pop together cannot occur, because `in_ready` = 0.
- `flush` forces `count` to 0 at the next edge. Flush wins over a same-cycle push and pop: the input is not accepted, and the consumer must ignore `out_valid` in a flush cycle.
- `rst` has the same effect as `flush` and also zeroes the data registers. `rst` has priority over everything.
- While `rst` or `flush` is held, the block still drives `in_ready` from current state, but nothing is pushed.
- Illegal parameters (`IMM_W` > `OUT_W` − 2) must fail elaboration via a generate-time check.

## Timing
- Reset values: `count` = 0, `out_valid` = 0, `in_ready` = 1, `out_imm` = 0, `out_tag` = 0.
- Latency: an item pushed at edge N, into an empty buffer, is visible on `out_*` with `out_valid` = 1 after edge N, i.e. 1 cycle.
- Throughput is 1 item per cycle while `out_ready` stays high.
- Back-pressure:
  - If `out_ready` drops while `count` = 1 and a push occurs, `count` becomes 2 and `in_ready` falls in the following cycle.
  - No item is lost or duplicated.
- Release:
  - From `count` = 2, the first pop gives `count` = 1 and `in_ready` = 1 the next cycle.
  - One further cycle later, a push can land.
- Head data must stay stable while `out_valid && !out_ready`.

## Test plan
- Mode sweep (defaults), each with `out_ready` = 1:
  - `in_imm` = 0x8004, mode 0 → `out_imm` = 0x00008004.
  - mode 1 → 0xFFFF8004.
  - mode 2 → 0x80040000.
  - mode 3 → 0xFFFE0010.
  - Each appears 1 cycle after acceptance.
- Back-pressure: hold `out_ready` = 0 and push tags 1, 2, 3 on consecutive cycles.
  - Tags 1 and 2 are accepted; `count` = 2; `in_ready` = 0 while tag 3 is held.
  - Release `out_ready` → output order is 1, 2, 3, with no drops or duplicates.
- Simultaneous push and pop at `count` = 1:
  - `count` stays 1.
  - The head becomes the new entry in the following cycle.
- Flush: with `count` = 2, assert `flush` together with `in_valid` = 1.
  - Next cycle: `count` = 0, `out_valid` = 0, `in_ready` = 1.
  - The flushed-cycle input is not present.
- Mid-operation reset: assert `rst` with `count` = 2 and `out_ready` = 1.
  - Next cycle all outputs are at reset values, and no pop is counted.
- Parametrisation: `IMM_W` = 12, `OUT_W` = 32, `in_imm` = 0x800.
  - mode 1 → 0xFFFFF800.
  - mode 2 → 0x80000000.
  - mode 3 → 0xFFFFE000.
  - Randomised push/pop against a reference queue model for 10k cycles, with no mismatches.
